// File: rtl/neuro_pkg.sv
// Shared widths, state encodings and report layout for the spike window monitor.
package neuro_pkg;

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned DT_W     = 8;
    localparam int unsigned WEIGHT_W = 6;
    localparam int unsigned WDELTA_W = WEIGHT_W + 1;

    localparam logic [DT_W-1:0] DT_NONE = '1;

    typedef enum logic {
        WIN_INIT,
        WIN_RUN
    } win_state_e;

    typedef enum logic {
        OUT_EMPTY,
        OUT_FULL
    } out_state_e;

    typedef struct packed {
        logic [CNT_W-1:0]    pre_cnt;
        logic [CNT_W-1:0]    post_cnt;
        logic [DT_W-1:0]     last_dt;
        logic [WDELTA_W-1:0] wdelta;
        logic                overflow;
        logic                dropped;
    } report_t;

endpackage

// File: rtl/spike_window_monitor_if.sv
// Valid/ready report port of the spike window monitor.
interface spike_window_monitor_if #(
    parameter int unsigned CNT_W = neuro_pkg::CNT_W,
    parameter int unsigned DT_W  = neuro_pkg::DT_W
);
    logic                              out_valid;
    logic                              out_ready;
    logic [CNT_W-1:0]                  out_pre_cnt;
    logic [CNT_W-1:0]                  out_post_cnt;
    logic [DT_W-1:0]                   out_last_dt;
    logic [neuro_pkg::WDELTA_W-1:0]    out_wdelta;
    logic                              out_overflow;
    logic                              out_dropped;

    modport master (
        output out_valid, out_pre_cnt, out_post_cnt, out_last_dt,
               out_wdelta, out_overflow, out_dropped,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_pre_cnt, out_post_cnt, out_last_dt,
               out_wdelta, out_overflow, out_dropped,
        output out_ready
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; nxt is this cycle's incremented value before any clear.
module sat_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter logic        RST_ONES = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] nxt,
    output logic             sat
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        sat   = &cnt_q;
        nxt   = (inc && !sat) ? cnt_q + WIDTH'(1) : cnt_q;
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = clr ? '0 : nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {WIDTH{RST_ONES}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/spike_window_monitor.sv
// Windowed pre/post spike statistics with a single-entry valid/ready report register.
module spike_window_monitor #(
    parameter int unsigned WINDOW_CYCLES = 256,
    parameter int unsigned CNT_W         = neuro_pkg::CNT_W,
    parameter int unsigned DT_W          = neuro_pkg::DT_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    input  logic                           spike_pre,
    input  logic                           spike_post,
    input  logic [neuro_pkg::WEIGHT_W-1:0] weight,
    spike_window_monitor_if.master         rpt
);
    import neuro_pkg::*;

    localparam int unsigned     IDX_W    = $clog2(WINDOW_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WINDOW_CYCLES - 1);

    typedef struct packed {
        logic [CNT_W-1:0]    pre_cnt;
        logic [CNT_W-1:0]    post_cnt;
        logic [DT_W-1:0]     last_dt;
        logic [WDELTA_W-1:0] wdelta;
        logic                overflow;
        logic                dropped;
    } rpt_t;

    win_state_e          win_q, win_d;
    out_state_e          out_q, out_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WEIGHT_W-1:0] base_q, base_d;
    logic [DT_W-1:0]     last_dt_q, last_dt_d;
    logic                ovf_q, ovf_d;
    logic                drop_q, drop_d;
    rpt_t                rpt_q, rpt_d;

    logic             close, capture, xfer;
    logic             pre_sat, post_sat, dt_sat;
    logic [CNT_W-1:0] pre_nxt, post_nxt;
    logic [DT_W-1:0]  dt_nxt;
    logic             ovf_now;
    logic [DT_W-1:0]  last_dt_now;
    rpt_t             rpt_new;

    sat_counter #(.WIDTH(CNT_W), .RST_ONES(1'b0)) u_pre_cnt (
        .clk(clk), .rst_n(rst_n), .en(ena), .clr(close), .inc(spike_pre),
        .nxt(pre_nxt), .sat(pre_sat)
    );

    sat_counter #(.WIDTH(CNT_W), .RST_ONES(1'b0)) u_post_cnt (
        .clk(clk), .rst_n(rst_n), .en(ena), .clr(close), .inc(spike_post),
        .nxt(post_nxt), .sat(post_sat)
    );

    // Timer spans windows; a pre spike restarts it, otherwise it ages every enabled cycle.
    sat_counter #(.WIDTH(DT_W), .RST_ONES(1'b1)) u_dt_timer (
        .clk(clk), .rst_n(rst_n), .en(ena), .clr(spike_pre), .inc(1'b1),
        .nxt(dt_nxt), .sat(dt_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q     <= WIN_INIT;
            out_q     <= OUT_EMPTY;
            idx_q     <= '0;
            base_q    <= '0;
            last_dt_q <= '1;
            ovf_q     <= 1'b0;
            drop_q    <= 1'b0;
            rpt_q     <= '0;
        end else begin
            win_q     <= win_d;
            out_q     <= out_d;
            idx_q     <= idx_d;
            base_q    <= base_d;
            last_dt_q <= last_dt_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
            rpt_q     <= rpt_d;
        end
    end

    always_comb begin
        win_d  = win_q;
        idx_d  = idx_q;
        base_d = base_q;
        if (ena) begin
            idx_d = close ? '0 : idx_q + IDX_W'(1);
            if (win_q == WIN_INIT || close) begin
                base_d = weight;
            end
            if (win_q == WIN_INIT) begin
                win_d = WIN_RUN;
            end
        end

        // Close-cycle events are folded into the report, then the window restarts clean.
        ovf_now = ovf_q | (ena & ((spike_pre & pre_sat) | (spike_post & post_sat) |
                                  (~spike_pre & ~dt_sat & (&dt_nxt))));
        last_dt_now = last_dt_q;
        if (ena && spike_post) begin
            last_dt_now = spike_pre ? '0 : dt_nxt;
        end
        ovf_d     = close ? 1'b0 : ovf_now;
        last_dt_d = close ? '1 : last_dt_now;

        rpt_new.pre_cnt  = pre_nxt;
        rpt_new.post_cnt = post_nxt;
        rpt_new.last_dt  = last_dt_now;
        rpt_new.wdelta   = {1'b0, weight} - {1'b0, base_q};
        rpt_new.overflow = ovf_now;
        rpt_new.dropped  = drop_q;

        out_d  = out_q;
        drop_d = drop_q;
        rpt_d  = rpt_q;
        if (capture) begin
            out_d  = OUT_FULL;
            drop_d = 1'b0;
            rpt_d  = rpt_new;
        end else begin
            if (xfer) begin
                out_d = OUT_EMPTY;
            end
            if (close) begin
                drop_d = 1'b1;
            end
        end
    end

    always_comb begin
        close   = ena && (win_q == WIN_RUN) && (idx_q == IDX_LAST);
        xfer    = (out_q == OUT_FULL) && rpt.out_ready;
        capture = close && ((out_q == OUT_EMPTY) || rpt.out_ready);

        rpt.out_valid    = (out_q == OUT_FULL);
        rpt.out_pre_cnt  = rpt_q.pre_cnt;
        rpt.out_post_cnt = rpt_q.post_cnt;
        rpt.out_last_dt  = rpt_q.last_dt;
        rpt.out_wdelta   = rpt_q.wdelta;
        rpt.out_overflow = rpt_q.overflow;
        rpt.out_dropped  = rpt_q.dropped;
    end
endmodule

// File: tb/tb_spike_window_monitor.sv
// Directed bench for spike_window_monitor (16-cycle windows plus a narrow-counter 32-cycle instance).
module tb_spike_window_monitor;
    import neuro_pkg::*;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       ena        = 1'b0;
    logic       spike_pre  = 1'b0;
    logic       spike_post = 1'b0;
    logic [5:0] weight     = '0;
    logic       ena5       = 1'b0;
    logic       pre5       = 1'b0;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    spike_window_monitor_if #(.CNT_W(8), .DT_W(8)) mon_if ();
    spike_window_monitor_if #(.CNT_W(4), .DT_W(8)) mon5_if ();

    spike_window_monitor #(.WINDOW_CYCLES(16), .CNT_W(8), .DT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike_pre(spike_pre),
        .spike_post(spike_post), .weight(weight), .rpt(mon_if)
    );

    spike_window_monitor #(.WINDOW_CYCLES(32), .CNT_W(4), .DT_W(8)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .ena(ena5), .spike_pre(pre5),
        .spike_post(1'b0), .weight(6'd0), .rpt(mon5_if)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] got_rpt();
        report_t r;
        r.pre_cnt  = mon_if.out_pre_cnt;
        r.post_cnt = mon_if.out_post_cnt;
        r.last_dt  = mon_if.out_last_dt;
        r.wdelta   = mon_if.out_wdelta;
        r.overflow = mon_if.out_overflow;
        r.dropped  = mon_if.out_dropped;
        return {mon_if.out_valid, r};
    endfunction

    function automatic logic [33:0] exp_rpt(input int pre, input int post, input int dt,
                                             input int wd, input int ovf, input int drp);
        report_t r;
        r.pre_cnt  = CNT_W'(pre);
        r.post_cnt = CNT_W'(post);
        r.last_dt  = DT_W'(dt);
        r.wdelta   = WDELTA_W'(wd);
        r.overflow = 1'(ovf);
        r.dropped  = 1'(drp);
        return {1'b1, r};
    endfunction

    task automatic cyc(input logic pre, input logic post);
        spike_pre  = pre;
        spike_post = post;
        @(posedge clk);
        #1;
        spike_pre  = 1'b0;
        spike_post = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ena = 1'b0; ena5 = 1'b0; pre5 = 1'b0;
        spike_pre = 1'b0; spike_post = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        mon_if.out_ready  = 1'b1;
        mon5_if.out_ready = 1'b1;

        // 1: idle window, with a disabled gap whose spikes must be ignored
        do_reset();
        check("t1_reset", 64'(got_rpt()), 64'd0);
        weight = 6'd20; ena = 1'b1;
        run(8);
        ena = 1'b0; spike_pre = 1'b1; spike_post = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        spike_pre = 1'b0; spike_post = 1'b0; ena = 1'b1;
        run(7);
        check("t1_no_early_valid", 64'(mon_if.out_valid), 64'd0);
        run(1);
        check("t1_report", 64'(got_rpt()), 64'(exp_rpt(0, 0, 255, 0, 0, 0)));
        run(1);
        check("t1_valid_pulse", 64'(mon_if.out_valid), 64'd0);

        // 2: pre at 3, post at 8; following window has no post
        do_reset();
        ena = 1'b1;
        run(3); cyc(1'b1, 1'b0); run(4); cyc(1'b0, 1'b1); run(7);
        check("t2_dt5", 64'(got_rpt()), 64'(exp_rpt(1, 1, 5, 0, 0, 0)));
        run(16);
        check("t2_next_none", 64'(got_rpt()), 64'(exp_rpt(0, 0, 255, 0, 0, 0)));

        // 3: pair at 6 then post at 10; then pair alone
        do_reset();
        ena = 1'b1;
        run(6); cyc(1'b1, 1'b1); run(3); cyc(1'b0, 1'b1); run(5);
        check("t3_dt4", 64'(got_rpt()), 64'(exp_rpt(1, 2, 4, 0, 0, 0)));
        run(6); cyc(1'b1, 1'b1); run(9);
        check("t3_dt0", 64'(got_rpt()), 64'(exp_rpt(1, 1, 0, 0, 0, 0)));

        // 4: back-pressure across two closes
        do_reset();
        mon_if.out_ready = 1'b0; ena = 1'b1;
        cyc(1'b1, 1'b0); run(15);
        check("t4_r1", 64'(got_rpt()), 64'(exp_rpt(1, 0, 255, 0, 0, 0)));
        cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); run(6);
        check("t4_r1_held_mid", 64'(got_rpt()), 64'(exp_rpt(1, 0, 255, 0, 0, 0)));
        run(8);
        check("t4_r1_held_close2", 64'(got_rpt()), 64'(exp_rpt(1, 0, 255, 0, 0, 0)));
        mon_if.out_ready = 1'b1;
        cyc(1'b1, 1'b0);
        check("t4_xfer", 64'(mon_if.out_valid), 64'd0);
        cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); run(13);
        check("t4_r3_dropped", 64'(got_rpt()), 64'(exp_rpt(3, 0, 255, 0, 0, 1)));

        // 5: narrow counter saturation on the 32-cycle instance
        do_reset();
        ena5 = 1'b1; pre5 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        pre5 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("t5_valid", 64'(mon5_if.out_valid), 64'd1);
        check("t5_pre_sat", 64'(mon5_if.out_pre_cnt), 64'd15);
        check("t5_ovf", 64'(mon5_if.out_overflow), 64'd1);
        repeat (32) @(posedge clk);
        #1;
        check("t5_next_ovf", 64'(mon5_if.out_overflow), 64'd0);
        check("t5_next_pre", 64'(mon5_if.out_pre_cnt), 64'd0);
        ena5 = 1'b0;

        // 6: negative weight delta, then reset mid-window with a report pending
        do_reset();
        weight = 6'd10; ena = 1'b1;
        cyc(1'b0, 1'b0);
        weight = 6'd7;
        run(15);
        check("t6_wdelta", 64'(got_rpt()), 64'(exp_rpt(0, 0, 255, 'h7D, 0, 0)));
        mon_if.out_ready = 1'b0;
        run(9);
        rst_n = 1'b0;
        #1;
        check("t6_async_reset", 64'(got_rpt()), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; mon_if.out_ready = 1'b1;
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0);
        check("t6_no_partial", 64'(mon_if.out_valid), 64'd0);
        cyc(1'b1, 1'b0);
        check("t6_full_window", 64'(got_rpt()), 64'(exp_rpt(16, 0, 255, 0, 0, 0)));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/spike_window_monitor.md
Name: spike_window_monitor

Overview:
- Downstream observer for the two-LIF STDP core. It consumes the pre-neuron spike (core uio_out[7]), the post-neuron spike (uio_out[6]) and the 6-bit synaptic weight (uio_out[5:0]).
- Over fixed windows of enabled cycles it counts spikes, measures the most recent pre→post spike interval and computes the net weight change.
- Each window yields one report, delivered on a valid/ready port to the on-chip readout logic.
- It replaces testbench-side spike counting with synthesizable hardware.

Parameters:
- WINDOW_CYCLES, 256, enabled cycles per measurement window (≥4).
- CNT_W, 8, width of the per-window spike counters.
- DT_W, 8, width of the pre→post interval field; the all-ones value means "no pairing / saturated".

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ena  in  1  cycle enable; when low, all measurement state freezes.
- spike_pre  in  1  single-cycle pre-neuron spike pulse.
- spike_post  in  1  single-cycle post-neuron spike pulse.
- weight  in  6  current STDP weight, unsigned.
- out_ready  in  1  consumer accepts the report.
- out_valid  out  1  report available.
- out_pre_cnt  out  CNT_W  pre spikes in the window, saturating.
- out_post_cnt  out  CNT_W  post spikes in the window, saturating.
- out_last_dt  out  DT_W  cycles from the latest pre spike to the latest post spike in the window.
- out_wdelta  out  7  signed two's-complement weight change (end minus start).
- out_overflow  out  1  a counter or dt saturated during the window.
- out_dropped  out  1  at least one earlier report was lost since the previous captured report.

Behaviour:
- Single clock domain. Asynchronous active-low reset, clock = clk, reset = rst_n.
- Reset values:
  - All outputs 0.
  - Window counter 0; spike counters 0.
  - dt timer all-ones (no pre seen); last_dt all-ones.
  - Weight base 0; first window base is captured on the first enabled cycle after reset.
  - Dropped flag 0.
- Window FSM:
  - INIT: on the first ena=1 cycle, capture weight_base = weight and go to RUN. Spikes in that cycle count.
  - RUN: the window index increments on each ena=1 cycle and wraps at WINDOW_CYCLES-1.
  - The cycle with index WINDOW_CYCLES-1 is the close cycle. Spikes in the close cycle belong to the closing window.
- ena=0: no counting, no timer advance, no close, spikes ignored. The output handshake keeps operating.
- Counters: +1 per spike cycle, saturating at 2^CNT_W-1. A spike arriving at saturation sets overflow.
- dt timer:
  - On a pre spike, timer := 0; otherwise timer +1 per enabled cycle, saturating at all-ones.
  - On a post spike, last_dt := 0 if pre fires in the same cycle, else last_dt := timer.
  - Reaching saturation sets overflow.
  - The timer persists across windows. last_dt resets to all-ones at each close.
- Weight delta:
  - At close, wdelta = {1'b0,weight} − {1'b0,weight_base}, 7-bit signed (range −63..+63).
  - At close, weight_base := weight.
- Close cycle: counters, overflow and last_dt reload to their per-window initial values on the next cycle. Spikes in the close cycle are included in the report; the next window starts clean.
- Output register (states EMPTY/FULL):
  - At close, if EMPTY, or FULL with out_ready=1 in the same cycle: capture the report. out_valid=1 on the next cycle (latency 1). out_dropped := dropped flag, and the flag clears.
  - At close, if FULL with out_ready=0: discard the report and set the dropped flag.
  - Transfer occurs on out_valid & out_ready. With no new capture, go to EMPTY and drop out_valid the next cycle.
  - Data stays stable while out_valid=1 and out_ready=0.
- Reset mid-window or mid-handshake: immediate return to the reset state. The pending report is lost and no report is emitted for the partial window.

Decomposition:
- Package neuro_pkg holds:
  - Default widths: CNT_W, DT_W, WEIGHT_W=6.
  - A packed report typedef (pre_cnt, post_cnt, last_dt, wdelta, overflow, dropped).
  - The DT_NONE constant (all-ones).
- Sub-module sat_counter, parameterised width, with inc/clr/en inputs and a sat flag. It is instantiated for both spike counters and the dt timer.

Test Plan:
All scenarios use WINDOW_CYCLES=16 unless stated.
1. Reset release, ena=1, no spikes, weight=20, ready=1 → out_valid pulses one cycle after the 16th cycle. Report: cnts 0, dt=8'hFF, wdelta 0, overflow 0, dropped 0.
2. pre at window index 3, post at index 8 → pre_cnt 1, post_cnt 1, last_dt 5. The next window reports dt 8'hFF if it has no post spike.
3. pre and post together at index 6, then post alone at index 10 → last_dt 4. The same-cycle pair alone (no later post) → last_dt 0.
4. ready=0 across 2 closes, then ready=1 → report 1 is held stable and delivered with dropped=0. Report 2 is lost. Report 3 carries dropped=1.
5. CNT_W=4, WINDOW_CYCLES=32, pre every cycle for 20 cycles → pre_cnt 15, overflow 1. The following window starts with overflow 0.
6. Weight 10 at window start, 7 at close → wdelta 7'h7D (−3). Assert rst_n=0 at index 9 of the next window → all outputs 0 at once, and the next report covers a full 16 cycles.
